// File: rtl/full_split.sv
// Boolean masking front end: splits one K_WIDTH-bit word into N_SHARES XOR shares.
// Optional build macro FULL_SPLIT_ZEROIZE_EN clears stage data on enabled bubble cycles.
module full_split #(
    parameter int K_WIDTH  = 32,
    parameter int N_SHARES = 3,
    localparam int MASKWIDTH = K_WIDTH * N_SHARES,
    localparam int RANDNUM   = N_SHARES - 1,
    localparam int LAYERS    = N_SHARES - 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_dvld,
    input  logic                         i_rvld,
    input  logic [K_WIDTH-1:0]           i_x,
    input  logic [K_WIDTH*RANDNUM-1:0]   i_n,
    output logic [MASKWIDTH-1:0]         o_x,
    output logic                         o_dvld,
    output logic                         o_busy
);

    if (N_SHARES < 2) begin : g_bad_cfg
        $error("full_split: N_SHARES must be at least 2");
    end

    logic [LAYERS:1]    r_v;
    logic [K_WIDTH-1:0] r_s [1:LAYERS][N_SHARES];
    logic [K_WIDTH-1:0] r_n [1:LAYERS][RANDNUM];

    logic [LAYERS:1]    w_in_v;
    logic [K_WIDTH-1:0] w_in_s [1:LAYERS][N_SHARES];
    logic [K_WIDTH-1:0] w_in_n [1:LAYERS][RANDNUM];
    logic [K_WIDTH-1:0] w_nx_s [1:LAYERS][N_SHARES];
    logic [K_WIDTH-1:0] w_nx_n [1:LAYERS][RANDNUM];

    // Gather what each stage sees at its input: the raw word for stage 1, the previous stage otherwise.
    always_comb begin
        w_in_v = {LAYERS{1'b0}};
        for (int k = 1; k <= LAYERS; k++) begin
            for (int s = 0; s < N_SHARES; s++) begin
                w_in_s[k][s] = {K_WIDTH{1'b0}};
            end
            for (int j = 0; j < RANDNUM; j++) begin
                w_in_n[k][j] = {K_WIDTH{1'b0}};
            end
        end
        for (int k = 1; k <= LAYERS; k++) begin
            if (k == 1) begin
                w_in_v[k] = i_dvld;
                w_in_s[k][0] = i_x;
                for (int j = 0; j < RANDNUM; j++) begin
                    w_in_n[k][j] = i_n[j*K_WIDTH +: K_WIDTH];
                end
            end else begin
                w_in_v[k] = r_v[k-1];
                for (int s = 0; s < N_SHARES; s++) begin
                    w_in_s[k][s] = r_s[k-1][s];
                end
                for (int j = 0; j < RANDNUM; j++) begin
                    w_in_n[k][j] = r_n[k-1][j];
                end
            end
        end
    end

    // Stage k folds random word k-1 into share 0 and emits it as share k; consumed words are dropped.
    always_comb begin
        for (int k = 1; k <= LAYERS; k++) begin
            for (int s = 0; s < N_SHARES; s++) begin
                w_nx_s[k][s] = w_in_s[k][s];
            end
            w_nx_s[k][0] = w_in_s[k][0] ^ w_in_n[k][k-1];
            w_nx_s[k][k] = w_in_n[k][k-1];
            for (int j = 0; j < RANDNUM; j++) begin
                if (j < k) begin
                    w_nx_n[k][j] = {K_WIDTH{1'b0}};
                end else begin
                    w_nx_n[k][j] = w_in_n[k][j];
                end
            end
        end
    end

    // Pipeline registers: reset clears, i_rvld low freezes everything, data moves only with valid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_v <= {LAYERS{1'b0}};
            for (int k = 1; k <= LAYERS; k++) begin
                for (int s = 0; s < N_SHARES; s++) begin
                    r_s[k][s] <= {K_WIDTH{1'b0}};
                end
                for (int j = 0; j < RANDNUM; j++) begin
                    r_n[k][j] <= {K_WIDTH{1'b0}};
                end
            end
        end else if (i_rvld) begin
            r_v <= w_in_v;
            for (int k = 1; k <= LAYERS; k++) begin
                if (w_in_v[k]) begin
                    for (int s = 0; s < N_SHARES; s++) begin
                        r_s[k][s] <= w_nx_s[k][s];
                    end
                    for (int j = 0; j < RANDNUM; j++) begin
                        r_n[k][j] <= w_nx_n[k][j];
                    end
                end
`ifdef FULL_SPLIT_ZEROIZE_EN
                else begin
                    for (int s = 0; s < N_SHARES; s++) begin
                        r_s[k][s] <= {K_WIDTH{1'b0}};
                    end
                    for (int j = 0; j < RANDNUM; j++) begin
                        r_n[k][j] <= {K_WIDTH{1'b0}};
                    end
                end
`endif
            end
        end
    end

    // Outputs come straight from the last stage registers.
    always_comb begin
        o_x = {MASKWIDTH{1'b0}};
        for (int s = 0; s < N_SHARES; s++) begin
            o_x[s*K_WIDTH +: K_WIDTH] = r_s[LAYERS][s];
        end
        o_dvld = r_v[LAYERS];
        o_busy = |r_v;
    end

endmodule

// File: tb/tb_full_split.sv
// Randomized self-checking bench for full_split against a word-level split model.
module tb_full_split;
    localparam int K  = 32;
    localparam int N  = 3;
    localparam int MW = K * N;
    localparam int R  = N - 1;
    localparam int L  = N - 1;

    localparam logic [K*R-1:0] NB    = {32'h0F0F0F0F, 32'h12345678};
    localparam logic [MW-1:0]  BASIC = 96'h0F0F0F0F_12345678_C396E798;

    logic          clk = 1'b0;
    logic          rst_ni, i_dvld, i_rvld;
    logic [K-1:0]  i_x;
    logic [K*R-1:0] i_n;
    logic [MW-1:0] o_x;
    logic          o_dvld, o_busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;

    always #5 clk = ~clk;

    full_split #(.K_WIDTH(K), .N_SHARES(N)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .i_dvld(i_dvld),
        .i_rvld(i_rvld),
        .i_x   (i_x),
        .i_n   (i_n),
        .o_x   (o_x),
        .o_dvld(o_dvld),
        .o_busy(o_busy)
    );

    // Whole-word reference: share 0 = x ^ all randoms, share s = random word s-1.
    function automatic logic [MW-1:0] split_ref(input logic [K-1:0] x, input logic [K*R-1:0] n);
        logic [MW-1:0] r;
        logic [K-1:0]  acc;
        r   = {MW{1'b0}};
        acc = x;
        for (int j = 0; j < R; j++) begin
            acc = acc ^ n[j*K +: K];
            r[(j+1)*K +: K] = n[j*K +: K];
        end
        r[0 +: K] = acc;
        return r;
    endfunction

    function automatic logic [K-1:0] fold(input logic [MW-1:0] v);
        logic [K-1:0] acc;
        acc = {K{1'b0}};
        for (int s = 0; s < N; s++) begin
            acc = acc ^ v[s*K +: K];
        end
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a delay line of L words in flight plus the value last presented on o_x.
    logic [L-1:0]  m_v;
    logic [MW-1:0] m_d   [L];
    logic [K-1:0]  m_xin [L];
    logic [MW-1:0] m_out;

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_v   <= '0;
            m_out <= '0;
        end else if (i_rvld) begin
            for (int i = L - 1; i > 0; i--) begin
                m_v[i]   <= m_v[i-1];
                m_d[i]   <= m_d[i-1];
                m_xin[i] <= m_xin[i-1];
            end
            m_v[0]   <= i_dvld;
            m_d[0]   <= split_ref(i_x, i_n);
            m_xin[0] <= i_x;
            if (m_v[L-2]) begin
                m_out <= m_d[L-2];
            end else begin
`ifdef FULL_SPLIT_ZEROIZE_EN
                m_out <= '0;
`else
                m_out <= m_out;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_dvld", 128'(o_dvld), 128'(m_v[L-1]));
            chk("o_busy", 128'(o_busy), 128'(|m_v));
            chk("o_x", 128'(o_x), 128'(m_out));
            if (o_dvld) begin
                chk("xor_fold", 128'(fold(o_x)), 128'(m_xin[L-1]));
            end
        end
    end

    task automatic cyc(input logic rst, input logic rv, input logic dv,
                       input logic [K-1:0] x, input logic [K*R-1:0] n);
        rst_ni = rst;
        i_rvld = rv;
        i_dvld = dv;
        i_x    = x;
        i_n    = n;
        @(negedge clk);
    endtask

    logic [K-1:0] words [4];

    initial begin
        rst_ni = 1'b0; i_dvld = 1'b0; i_rvld = 1'b0; i_x = '0; i_n = '0;
        words[0] = 32'h00000000; words[1] = 32'hFFFFFFFF;
        words[2] = 32'h80000001; words[3] = 32'h12345678;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_dvld", 128'(o_dvld), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_x", 128'(o_x), 128'd0);
        chk("model_pin", 128'(split_ref(32'hDEADBEEF, NB)), 128'(BASIC));

        // basic
        cyc(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, NB);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
        chk("basic_dvld", 128'(o_dvld), 128'd1);
        chk("basic_x", 128'(o_x), 128'(BASIC));
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);

        // stall for three cycles after stage 1 loads
        cyc(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, NB);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 32'h55555555, {$urandom, $urandom});
            chk("stall_busy", 128'(o_busy), 128'd1);
            chk("stall_dvld", 128'(o_dvld), 128'd0);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
        chk("stall_dvld_out", 128'(o_dvld), 128'd1);
        chk("stall_x", 128'(o_x), 128'(BASIC));
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);

        // back-to-back words
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, words[i], {$urandom, $urandom});
            if (i > 0) begin
                chk("b2b_dvld", 128'(o_dvld), 128'd1);
                chk("b2b_fold", 128'(fold(o_x)), 128'(words[i-1]));
            end
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
        chk("b2b_dvld_last", 128'(o_dvld), 128'd1);
        chk("b2b_fold_last", 128'(fold(o_x)), 128'(words[3]));
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);

        // reset while stage 1 holds a word
        cyc(1'b1, 1'b1, 1'b1, 32'h13579BDF, {$urandom, $urandom});
        cyc(1'b0, 1'b1, 1'b1, 32'h2468ACE0, {$urandom, $urandom});
        chk("mrst_dvld", 128'(o_dvld), 128'd0);
        chk("mrst_busy", 128'(o_busy), 128'd0);
        chk("mrst_x", 128'(o_x), 128'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, NB);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
        chk("post_rst_x", 128'(o_x), 128'(BASIC));

        // bubble after the word leaves
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 64'h0);
        chk("bubble_dvld", 128'(o_dvld), 128'd0);
`ifdef FULL_SPLIT_ZEROIZE_EN
        chk("bubble_x", 128'(o_x), 128'd0);
`else
        chk("bubble_x", 128'(o_x), 128'(BASIC));
`endif

        // invalid input is ignored
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'hAAAAAAAA, {$urandom, $urandom});
        end
        chk("inv_dvld", 128'(o_dvld), 128'd0);
        chk("inv_busy", 128'(o_busy), 128'd0);

        // randomized traffic with stalls and occasional reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
